avalon_mm_pipeline_bridge: RTL and testbench

Single-clock, parametrised Avalon-MM bridge that buffers CPU-side commands and returns read data through a response FIFO, cutting timing paths between the CPU interconnect and a peripheral cluster. Successor to the dual-clock peripheral bridge for same-clock domains. It has parametrised data, address and FIFO sizes, credit-based read flow control in place of an almost-full threshold, and rejection of stale read responses after reset.

---
 rtl/avalon_bridge_pkg.sv | 27 ++
 rtl/bridge_sync_fifo.sv | 60 ++++++
 rtl/avalon_mm_pipeline_bridge.sv | 148 ++++++++++++++
 tb/tb_avalon_mm_pipeline_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_bridge_pkg.sv
// Shared widths, the command entry layout and width helpers for the Avalon-MM bridge.
package avalon_bridge_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 7;

  // Number of byte lanes for a given data width.
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Number of low byte-address bits implied by the data width.
  function automatic int byte_addr_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Command entry at the default widths. The top level builds its own entry
  // with the same field order from its parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W/8-1:0] be;
    logic [DEF_DATA_W-1:0]   wdata;
    logic                    read;
    logic                    write;
  } cmd_t;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with registered pointers and show-ahead read data.
// Callers never push when full or pop when empty.
module bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage array; not reset, the count qualifies its contents.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/avalon_mm_pipeline_bridge.sv
// Same-clock Avalon-MM pipeline bridge: command FIFO towards the peripherals,
// response FIFO back, with credit-limited reads and stale-response rejection.
module avalon_mm_pipeline_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int CMD_DEPTH = 32,
  parameter int RSP_DEPTH = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [ADDR_W-1:0]                     slave_address,
  input  logic [DATA_W/8-1:0]                   slave_byteenable,
  input  logic                                  slave_read,
  input  logic                                  slave_write,
  input  logic [DATA_W-1:0]                     slave_writedata,
  output logic                                  slave_waitrequest,
  output logic [DATA_W-1:0]                     slave_readdata,
  output logic                                  slave_readdatavalid,
  output logic [ADDR_W+byte_addr_w(DATA_W)-1:0] master_address,
  output logic [DATA_W/8-1:0]                   master_byteenable,
  output logic                                  master_read,
  output logic                                  master_write,
  output logic [DATA_W-1:0]                     master_writedata,
  input  logic                                  master_waitrequest,
  input  logic [DATA_W-1:0]                     master_readdata,
  input  logic                                  master_readdatavalid,
  output logic                                  stale_rsp
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int BA_W  = byte_addr_w(DATA_W);
  localparam int MA_W  = ADDR_W + BA_W;
  localparam int CC_W  = $clog2(CMD_DEPTH + 1);
  localparam int RC_W  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              read;
    logic              write;
  } cmd_entry_t;

  cmd_entry_t        cmd_in, cmd_head;
  logic              cmd_push, cmd_pop, cmd_empty, unused_cmd_full;
  logic [CC_W-1:0]   cmd_count;

  logic [DATA_W-1:0] rsp_head;
  logic              rsp_push, rsp_pop, rsp_empty, unused_rsp_full;
  logic [RC_W-1:0]   unused_rsp_count;

  logic [RC_W-1:0]   credits_q, credits_d;
  logic [RC_W-1:0]   outstanding_q, outstanding_d;
  logic              stale_q, stale_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdv_q, rdv_d;
  logic              read_issue;

  // A simultaneous read and write is stored as a write only.
  assign cmd_in.addr  = slave_address;
  assign cmd_in.be    = slave_byteenable;
  assign cmd_in.wdata = slave_writedata;
  assign cmd_in.read  = slave_read & ~slave_write;
  assign cmd_in.write = slave_write;

  assign slave_waitrequest = (cmd_count == CC_W'(CMD_DEPTH));
  assign cmd_push          = (slave_read | slave_write) & ~slave_waitrequest;

  bridge_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cmd_push),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (unused_cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  // A read at the head waits for a free response slot and blocks everything behind it.
  assign master_read       = ~cmd_empty & cmd_head.read & (credits_q < RC_W'(RSP_DEPTH));
  assign master_write      = ~cmd_empty & cmd_head.write;
  assign master_address    = MA_W'(cmd_head.addr) << BA_W;
  assign master_byteenable = cmd_head.be;
  assign master_writedata  = cmd_head.wdata;
  assign cmd_pop           = (master_read | master_write) & ~master_waitrequest;
  assign read_issue        = cmd_pop & cmd_head.read;

  // Data with nothing outstanding belongs to a read issued before reset.
  assign rsp_push = master_readdatavalid & (outstanding_q != '0);
  assign rsp_pop  = ~rsp_empty;

  bridge_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rsp_push),
    .wdata_i (master_readdata),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_head),
    .full_o  (unused_rsp_full),
    .empty_o (rsp_empty),
    .count_o (unused_rsp_count)
  );

  // Credit/outstanding bookkeeping, sticky stale flag and response output next-state.
  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q | (master_readdatavalid & (outstanding_q == '0));
    rdata_d       = rsp_pop ? rsp_head : rdata_q;
    rdv_d         = rsp_pop;
    case ({read_issue, rsp_pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
    case ({read_issue, rsp_push})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Counter, flag and response output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits_q     <= '0;
      outstanding_q <= '0;
      stale_q       <= 1'b0;
      rdata_q       <= '0;
      rdv_q         <= 1'b0;
    end else begin
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      rdata_q       <= rdata_d;
      rdv_q         <= rdv_d;
    end
  end

  assign slave_readdata      = rdata_q;
  assign slave_readdatavalid = rdv_q;
  assign stale_rsp           = stale_q;

endmodule

// File: tb/tb_avalon_mm_pipeline_bridge.sv
// Self-checking bench for avalon_mm_pipeline_bridge (CMD_DEPTH 32, RSP_DEPTH 4).
module tb_avalon_mm_pipeline_bridge;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int CD = 32;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] slave_address;
  logic [3:0]    slave_byteenable;
  logic          slave_read, slave_write;
  logic [DW-1:0] slave_writedata;
  logic          slave_waitrequest;
  logic [DW-1:0] slave_readdata;
  logic          slave_readdatavalid;
  logic [8:0]    master_address;
  logic [3:0]    master_byteenable;
  logic          master_read, master_write;
  logic [DW-1:0] master_writedata;
  logic          master_waitrequest;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid;
  logic          stale_rsp;

  int n_cmp = 0;
  int n_err = 0;

  avalon_mm_pipeline_bridge #(.DATA_W(DW), .ADDR_W(AW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .slave_address        (slave_address),
    .slave_byteenable     (slave_byteenable),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_waitrequest    (slave_waitrequest),
    .slave_readdata       (slave_readdata),
    .slave_readdatavalid  (slave_readdatavalid),
    .master_address       (master_address),
    .master_byteenable    (master_byteenable),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .stale_rsp            (stale_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    slave_address        = '0;
    slave_byteenable     = '0;
    slave_read           = 1'b0;
    slave_write          = 1'b0;
    slave_writedata      = '0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    master_waitrequest = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (slave_waitrequest !== 1'b0) begin n_err++; $display("FAIL reset_waitreq: got %b want 0", slave_waitrequest); end
    n_cmp++; if (slave_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv: got %b want 0", slave_readdatavalid); end
    n_cmp++; if (slave_readdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", slave_readdata); end
    n_cmp++; if (master_read !== 1'b0) begin n_err++; $display("FAIL reset_mread: got %b want 0", master_read); end
    n_cmp++; if (master_write !== 1'b0) begin n_err++; $display("FAIL reset_mwrite: got %b want 0", master_write); end
    n_cmp++; if (stale_rsp !== 1'b0) begin n_err++; $display("FAIL reset_stale: got %b want 0", stale_rsp); end
  endtask

  task automatic test_single_write();
    slave_write = 1'b1; slave_address = 7'h05; slave_byteenable = 4'hF; slave_writedata = 32'hDEADBEEF;
    cyc();
    idle();
    n_cmp++; if (master_write !== 1'b1) begin n_err++; $display("FAIL sw_mwrite: got %b want 1", master_write); end
    n_cmp++; if (master_read !== 1'b0) begin n_err++; $display("FAIL sw_mread: got %b want 0", master_read); end
    n_cmp++; if (master_address !== 9'h014) begin n_err++; $display("FAIL sw_addr: got %h want 014", master_address); end
    n_cmp++; if (master_byteenable !== 4'hF) begin n_err++; $display("FAIL sw_be: got %h want f", master_byteenable); end
    n_cmp++; if (master_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata: got %h want deadbeef", master_writedata); end
    cyc();
    n_cmp++; if (master_write !== 1'b0) begin n_err++; $display("FAIL sw_one_pop: got %b want 0", master_write); end
  endtask

  task automatic test_wait_read();
    slave_read = 1'b1; slave_address = 7'h2A; slave_byteenable = 4'h3;
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (master_read !== 1'b1) begin n_err++; $display("FAIL wr_stable_read[%0d]: got %b want 1", i, master_read); end
      n_cmp++; if (master_address !== 9'h0A8) begin n_err++; $display("FAIL wr_stable_addr[%0d]: got %h want 0a8", i, master_address); end
      n_cmp++; if (master_byteenable !== 4'h3) begin n_err++; $display("FAIL wr_stable_be[%0d]: got %h want 3", i, master_byteenable); end
      master_waitrequest = (i < 3);
      cyc();
    end
    n_cmp++; if (master_read !== 1'b0) begin n_err++; $display("FAIL wr_popped: got %b want 0", master_read); end
    master_readdatavalid = 1'b1; master_readdata = 32'h12345678;
    cyc();
    idle();
    n_cmp++; if (slave_readdatavalid !== 1'b0) begin n_err++; $display("FAIL wr_rdv_n1: got %b want 0", slave_readdatavalid); end
    cyc();
    n_cmp++; if (slave_readdatavalid !== 1'b1) begin n_err++; $display("FAIL wr_rdv_n2: got %b want 1", slave_readdatavalid); end
    n_cmp++; if (slave_readdata !== 32'h12345678) begin n_err++; $display("FAIL wr_rdata_n2: got %h want 12345678", slave_readdata); end
    cyc();
    n_cmp++; if (slave_readdatavalid !== 1'b0) begin n_err++; $display("FAIL wr_rdv_n3: got %b want 0", slave_readdatavalid); end
    n_cmp++; if (slave_readdata !== 32'h12345678) begin n_err++; $display("FAIL wr_rdata_hold: got %h want 12345678", slave_readdata); end
  endtask

  task automatic test_full();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 33; i++) begin
      n_cmp++; if (slave_waitrequest !== (i >= CD)) begin n_err++; $display("FAIL full_wait[%0d]: got %b want %b", i, slave_waitrequest, (i >= CD)); end
      slave_write = 1'b1; slave_address = 7'(i); slave_byteenable = 4'hF; slave_writedata = 32'(i);
      cyc();
    end
    idle();
    n_cmp++; if (slave_waitrequest !== 1'b1) begin n_err++; $display("FAIL full_held: got %b want 1", slave_waitrequest); end
    n_cmp++; if (master_writedata !== 32'd0) begin n_err++; $display("FAIL full_head0: got %h want 0", master_writedata); end
    master_waitrequest = 1'b0;
    cyc();
    n_cmp++; if (slave_waitrequest !== 1'b0) begin n_err++; $display("FAIL full_drop: got %b want 0", slave_waitrequest); end
    for (int k = 1; k < CD; k++) begin
      n_cmp++; if (master_write !== 1'b1 || master_writedata !== 32'(k)) begin n_err++; $display("FAIL full_order[%0d]: got %b/%h want 1/%h", k, master_write, master_writedata, k); end
      cyc();
    end
    n_cmp++; if (master_write !== 1'b0) begin n_err++; $display("FAIL full_33rd_dropped: got %b want 0", master_write); end
  endtask

  task automatic test_credit();
    int pops, owed, rcv;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      if (master_read && !master_waitrequest) pops++;
      slave_read = (c < 6); slave_address = 7'(c); slave_byteenable = 4'hF;
      cyc();
    end
    idle();
    n_cmp++; if (pops !== RD) begin n_err++; $display("FAIL credit_pops: got %0d want %0d", pops, RD); end
    n_cmp++; if (master_read !== 1'b0) begin n_err++; $display("FAIL credit_stall: got %b want 0", master_read); end
    master_readdatavalid = 1'b1; master_readdata = 32'hA5A5_0001;
    cyc();
    idle();
    n_cmp++; if (master_read !== 1'b0) begin n_err++; $display("FAIL credit_not_drained: got %b want 0", master_read); end
    cyc();
    n_cmp++; if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL credit_rsp: got %b/%h want 1/a5a50001", slave_readdatavalid, slave_readdata); end
    n_cmp++; if (master_read !== 1'b1) begin n_err++; $display("FAIL credit_fifth: got %b want 1", master_read); end
    owed = RD - 1; rcv = 1;
    for (int c = 0; c < 20; c++) begin
      master_readdatavalid = (owed > 0);
      master_readdata = 32'hA5A5_0000 + 32'(c);
      if (owed > 0) owed--;
      if (master_read && !master_waitrequest) begin pops++; owed++; end
      cyc();
      if (slave_readdatavalid) rcv++;
    end
    idle();
    n_cmp++; if (pops !== 6) begin n_err++; $display("FAIL credit_total_pops: got %0d want 6", pops); end
    n_cmp++; if (rcv !== 6) begin n_err++; $display("FAIL credit_total_rsp: got %0d want 6", rcv); end
  endtask

  task automatic test_rw_both();
    int pops, owed, rcv;
    slave_read = 1'b1; slave_write = 1'b1; slave_address = 7'h03; slave_byteenable = 4'hF; slave_writedata = 32'h55;
    cyc();
    idle();
    n_cmp++; if (master_write !== 1'b1 || master_read !== 1'b0) begin n_err++; $display("FAIL rw_strobes: got w%b r%b want w1 r0", master_write, master_read); end
    n_cmp++; if (master_address !== 9'h00C) begin n_err++; $display("FAIL rw_addr: got %h want 00c", master_address); end
    cyc();
    n_cmp++; if (master_write !== 1'b0 || master_read !== 1'b0) begin n_err++; $display("FAIL rw_single: got w%b r%b want w0 r0", master_write, master_read); end
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      if (master_read && !master_waitrequest) pops++;
      slave_read = (c < RD); slave_address = 7'(c); slave_byteenable = 4'hF;
      cyc();
    end
    idle();
    n_cmp++; if (pops !== RD) begin n_err++; $display("FAIL rw_credits_zero: got %0d reads want %0d", pops, RD); end
    owed = pops; rcv = 0;
    for (int c = 0; c < 10; c++) begin
      master_readdatavalid = (owed > 0);
      if (owed > 0) owed--;
      cyc();
      if (slave_readdatavalid) rcv++;
    end
    idle();
    n_cmp++; if (rcv !== RD) begin n_err++; $display("FAIL rw_rsp_count: got %0d want %0d", rcv, RD); end
  endtask

  task automatic test_reset_stale();
    for (int c = 0; c < 5; c++) begin
      slave_read = (c < 2); slave_address = 7'(c + 9); slave_byteenable = 4'hF;
      cyc();
    end
    master_waitrequest = 1'b1;
    slave_read = 1'b0; slave_write = 1'b1; slave_address = 7'h01;
    cyc();
    idle();
    n_cmp++; if (master_write !== 1'b1) begin n_err++; $display("FAIL stale_queued_write: got %b want 1", master_write); end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    master_waitrequest = 1'b0;
    n_cmp++; if (master_write !== 1'b0 || master_read !== 1'b0) begin n_err++; $display("FAIL stale_discard: got w%b r%b want w0 r0", master_write, master_read); end
    n_cmp++; if (stale_rsp !== 1'b0) begin n_err++; $display("FAIL stale_pre: got %b want 0", stale_rsp); end
    for (int c = 0; c < 6; c++) begin
      master_readdatavalid = (c < 2); master_readdata = 32'hBAD0_0000 + 32'(c);
      cyc();
      n_cmp++; if (slave_readdatavalid !== 1'b0) begin n_err++; $display("FAIL stale_rdv[%0d]: got %b want 0", c, slave_readdatavalid); end
    end
    idle();
    n_cmp++; if (stale_rsp !== 1'b1) begin n_err++; $display("FAIL stale_set: got %b want 1", stale_rsp); end
    do_reset();
    n_cmp++; if (stale_rsp !== 1'b0) begin n_err++; $display("FAIL stale_clear: got %b want 0", stale_rsp); end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    bit            rd;
    bit            wr;
  } exp_cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_rsp_t;

  // Reference model: commands leave in order; each read occupies one of RD
  // slots until its data is handed back; returned data appears two cycles later.
  task automatic test_random();
    exp_cmd_t cmd_q[$];
    exp_rsp_t rsp_q[$];
    exp_cmd_t e, h;
    exp_rsp_t r;
    int pend, issued, delivered, cyc_n;
    bit exp_mr, exp_mw, exp_full, rd, wr;
    pend = 0; issued = 0; delivered = 0; cyc_n = 0;
    for (int c = 0; c < 2300; c++) begin
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc_n) begin
        r = rsp_q.pop_front();
        delivered++;
        n_cmp++; if (slave_readdatavalid !== 1'b1 || slave_readdata !== r.data) begin n_err++; $display("FAIL rnd_rsp c%0d: got %b/%h want 1/%h", cyc_n, slave_readdatavalid, slave_readdata, r.data); end
      end else begin
        n_cmp++; if (slave_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rnd_rdv_idle c%0d: got %b want 0", cyc_n, slave_readdatavalid); end
      end
      exp_full = (cmd_q.size() == CD);
      n_cmp++; if (slave_waitrequest !== exp_full) begin n_err++; $display("FAIL rnd_waitreq c%0d: got %b want %b", cyc_n, slave_waitrequest, exp_full); end
      exp_mr = 1'b0; exp_mw = 1'b0;
      if (cmd_q.size() > 0) begin
        h = cmd_q[0];
        exp_mw = h.wr;
        exp_mr = h.rd && ((issued - delivered) < RD);
      end
      n_cmp++; if (master_read !== exp_mr || master_write !== exp_mw) begin n_err++; $display("FAIL rnd_strobes c%0d: got r%b w%b want r%b w%b", cyc_n, master_read, master_write, exp_mr, exp_mw); end
      if (exp_mr || exp_mw) begin
        n_cmp++; if (master_address !== {h.addr, 2'b00} || master_byteenable !== h.be) begin n_err++; $display("FAIL rnd_addr c%0d: got %h/%h want %h/%h", cyc_n, master_address, master_byteenable, {h.addr, 2'b00}, h.be); end
        if (exp_mw) begin
          n_cmp++; if (master_writedata !== h.wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc_n, master_writedata, h.wdata); end
        end
      end
      if (c >= 2000 && cmd_q.size() == 0 && rsp_q.size() == 0 && pend == 0) break;
      // drive this cycle
      master_waitrequest = ($urandom_range(0, 3) == 0);
      master_readdatavalid = (pend > 0) && ((c >= 2000) || $urandom_range(0, 1) == 1);
      master_readdata = $urandom;
      if (master_readdatavalid) begin
        pend--;
        r.data = master_readdata; r.due = cyc_n + 2;
        rsp_q.push_back(r);
      end
      if ((exp_mr || exp_mw) && !master_waitrequest) begin
        if (h.rd) begin issued++; pend++; end
        void'(cmd_q.pop_front());
      end
      rd = (c < 2000) && ($urandom_range(0, 2) != 0);
      wr = (c < 2000) && ($urandom_range(0, 2) == 0);
      slave_read = rd; slave_write = wr;
      slave_address = AW'($urandom); slave_byteenable = 4'($urandom); slave_writedata = $urandom;
      if ((rd || wr) && !exp_full) begin
        e.addr = slave_address; e.be = slave_byteenable; e.wdata = slave_writedata;
        e.rd = rd && !wr; e.wr = wr;
        cmd_q.push_back(e);
      end
      cyc();
      cyc_n++;
    end
    idle();
    master_waitrequest = 1'b0;
    n_cmp++; if (cmd_q.size() != 0 || rsp_q.size() != 0 || pend != 0) begin n_err++; $display("FAIL rnd_drain: cmd %0d rsp %0d pend %0d left, want all 0", cmd_q.size(), rsp_q.size(), pend); end
    n_cmp++; if (stale_rsp !== 1'b0) begin n_err++; $display("FAIL rnd_stale: got %b want 0", stale_rsp); end
  endtask

  initial begin
    reset_n = 1'b0;
    master_waitrequest = 1'b0;
    idle();
    cyc();
    test_reset();
    test_single_write();
    test_wait_read();
    test_full();
    test_credit();
    test_rw_both();
    test_reset_stale();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
